// File: rtl/halt_ctrl_pkg.sv
// Shared processor constants for the run/halt/step controller.
// Holds state encodings, default parameters and small width helpers.
package halt_ctrl_pkg;

    localparam int DEB_CYCLES_DEFAULT = 250000;
    localparam int CNT_W_DEFAULT      = 16;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2
    } halt_state_t;

    // Counter width able to hold the value 'cycles' (never narrower than 1 bit).
    function automatic int deb_cnt_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-flop synchronizer, stable-level debouncer
// and rising-edge detector producing a one-cycle press pulse.
module btn_debounce
    import halt_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic entClk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = deb_cnt_w(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge entClk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_q <= stable;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = stable & ~stable_q;

endmodule

// File: rtl/halt_ctrl.sv
// Run/halt/single-step controller driving the processor clock divider freeze.
// Buttons are conditioned by two btn_debounce instances feeding one FSM.
//
// state  | meaning
// HALTED | divider frozen, waiting for a run or step press
// RUN    | divider free-running until HLT or a run press
// STEP   | divider released for exactly one divided-clock rising edge
module halt_ctrl
    import halt_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             entClk,
    input  logic             rst,
    input  logic             btnRun,
    input  logic             btnStep,
    input  logic             haltInstr,
    input  logic             saidaClk,
    output logic             halt,
    output logic             running,
    output logic             stepDone,
    output logic [CNT_W-1:0] stepCnt
);

    halt_state_t state;
    logic        runPress;
    logic        stepPress;
    logic        saida_q;
    logic        saidaRise;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .entClk (entClk),
        .rst    (rst),
        .btn    (btnRun),
        .press  (runPress)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .entClk (entClk),
        .rst    (rst),
        .btn    (btnStep),
        .press  (stepPress)
    );

    assign saidaRise = saidaClk & ~saida_q;

    always_ff @(posedge entClk or posedge rst) begin
        if (rst) begin
            state    <= HALTED;
            halt     <= 1'b1;
            running  <= 1'b0;
            stepDone <= 1'b0;
            stepCnt  <= '0;
            saida_q  <= 1'b0;
        end else begin
            saida_q  <= saidaClk;
            stepDone <= 1'b0;
            case (state)
                HALTED: begin
                    // Run has priority when both buttons land in the same cycle.
                    if (runPress) begin
                        state   <= RUN;
                        halt    <= 1'b0;
                        running <= 1'b1;
                    end else if (stepPress) begin
                        state   <= STEP;
                        halt    <= 1'b0;
                        running <= 1'b0;
                    end
                end
                RUN: begin
                    if (haltInstr || runPress) begin
                        state   <= HALTED;
                        halt    <= 1'b1;
                        running <= 1'b0;
                    end
                end
                STEP: begin
                    // HLT and run presses are deliberately ignored mid-step.
                    if (saidaRise) begin
                        state    <= HALTED;
                        halt     <= 1'b1;
                        stepDone <= 1'b1;
                        stepCnt  <= stepCnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= HALTED;
                    halt    <= 1'b1;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halt_ctrl.sv
// Self-checking bench for halt_ctrl: directed scenarios plus random stimulus
// compared every cycle against a window-based behavioural model.
module tb_halt_ctrl;

    localparam int DEB   = 4;
    localparam int CW    = 4;
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic          entClk = 1'b0;
    logic          rst    = 1'b1;
    logic          btnRun = 1'b0;
    logic          btnStep = 1'b0;
    logic          haltInstr = 1'b0;
    logic          saidaClk = 1'b0;
    logic          halt;
    logic          running;
    logic          stepDone;
    logic [CW-1:0] stepCnt;

    halt_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .entClk    (entClk),
        .rst       (rst),
        .btnRun    (btnRun),
        .btnStep   (btnStep),
        .haltInstr (haltInstr),
        .saidaClk  (saidaClk),
        .halt      (halt),
        .running   (running),
        .stepDone  (stepDone),
        .stepCnt   (stepCnt)
    );

    always #5 entClk = ~entClk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: a level is accepted once the last DEB synchronized
    // samples all disagree with the currently accepted level.
    int m_mode;
    int m_cnt;
    bit m_done;
    bit m_sp;
    bit s1   [2];
    bit s2   [2];
    bit stab [2];
    bit stabq[2];
    bit win  [2][DEB];

    task automatic m_reset();
        m_mode = M_HALT;
        m_cnt  = 0;
        m_done = 0;
        m_sp   = 0;
        for (int b = 0; b < 2; b++) begin
            s1[b] = 0; s2[b] = 0; stab[b] = 0; stabq[b] = 0;
            for (int k = 0; k < DEB; k++) win[b][k] = 0;
        end
    endtask

    task automatic m_step();
        bit pr_run, pr_step, rise, samp, alld;
        bit raw[2];
        pr_run  = stab[0] & ~stabq[0];
        pr_step = stab[1] & ~stabq[1];
        rise    = saidaClk & ~m_sp;
        m_done  = 0;
        case (m_mode)
            M_HALT: begin
                if (pr_run) m_mode = M_RUN;
                else if (pr_step) m_mode = M_STEP;
            end
            M_RUN: if (haltInstr || pr_run) m_mode = M_HALT;
            default: if (rise) begin
                m_mode = M_HALT;
                m_done = 1;
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end
        endcase
        m_sp   = saidaClk;
        raw[0] = btnRun;
        raw[1] = btnStep;
        for (int b = 0; b < 2; b++) begin
            samp  = s2[b];
            s2[b] = s1[b];
            s1[b] = raw[b];
            for (int k = DEB - 1; k > 0; k--) win[b][k] = win[b][k-1];
            win[b][0] = samp;
            alld = 1;
            for (int k = 0; k < DEB; k++) if (win[b][k] == stab[b]) alld = 0;
            stabq[b] = stab[b];
            if (alld) stab[b] = ~stab[b];
        end
    endtask

    bit div_en = 0;
    int div_ph = 0;
    int n_done = 0;
    int n_run_rise = 0;
    bit run_prev = 0;

    task automatic tick();
        @(posedge entClk);
        if (!rst) m_step();
        #1;
        chk("halt",     32'(halt),     32'(m_mode == M_HALT));
        chk("running",  32'(running),  32'(m_mode == M_RUN));
        chk("stepDone", 32'(stepDone), 32'(m_done));
        chk("stepCnt",  32'(stepCnt),  32'(m_cnt));
        if (stepDone) n_done++;
        if (running && !run_prev) n_run_rise++;
        run_prev = running;
        if (div_en) begin
            div_ph++;
            if (div_ph % 2 == 0) saidaClk = ~saidaClk;
        end
    endtask

    task automatic do_reset();
        @(negedge entClk);
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst_halt",    32'(halt),     32'd1);
        chk("rst_running", 32'(running),  32'd0);
        chk("rst_cnt",     32'(stepCnt),  32'd0);
        chk("rst_done",    32'(stepDone), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        run_prev = running;
    endtask

    task automatic press(input bit r, input bit s);
        btnRun  = r;
        btnStep = s;
        repeat (6) tick();
        btnRun  = 1'b0;
        btnStep = 1'b0;
        repeat (10) tick();
    endtask

    int first, d0, c0, hr, hs;

    initial begin
        m_reset();
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("init_halt", 32'(halt), 32'd1);

        // Bounce: 2-cycle toggling, then steady high.
        n_run_rise = 0;
        for (int i = 0; i < 20; i++) begin
            btnRun = ((i / 2) % 2 == 0);
            tick();
        end
        btnRun = 1'b1;
        first = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (running && first < 0) first = t;
        end
        btnRun = 1'b0;
        repeat (10) tick();
        chk("bounce_latency", 32'(first), 32'd7);
        chk("bounce_entries", 32'(n_run_rise), 32'd1);

        // HLT for one cycle in RUN.
        haltInstr = 1'b1;
        tick();
        haltInstr = 1'b0;
        chk("hlt_running", 32'(running), 32'd0);
        chk("hlt_halt",    32'(halt),    32'd1);

        // Single step with a free-running divider.
        div_en = 1;
        d0 = n_done;
        press(1'b0, 1'b1);
        repeat (6) tick();
        chk("step_pulses", 32'(n_done - d0), 32'd1);
        chk("step_cnt",    32'(stepCnt),     32'd1);
        chk("step_halt",   32'(halt),        32'd1);

        // Simultaneous presses: run wins, no count change.
        press(1'b1, 1'b1);
        chk("simul_running", 32'(running), 32'd1);
        chk("simul_cnt",     32'(stepCnt), 32'd1);

        // Asynchronous reset while running with a nonzero count.
        do_reset();
        repeat (3) tick();
        chk("post_rst_halt", 32'(halt),    32'd1);
        chk("post_rst_cnt",  32'(stepCnt), 32'd0);

        // Reset mid-step aborts the step.
        div_en = 0;
        saidaClk = 1'b0;
        d0 = n_done;
        btnStep = 1'b1;
        repeat (6) tick();
        btnStep = 1'b0;
        repeat (3) tick();
        chk("midstep_halt", 32'(halt), 32'd0);
        do_reset();
        div_en = 1;
        repeat (10) tick();
        chk("midstep_done", 32'(n_done - d0), 32'd0);
        chk("midstep_cnt",  32'(stepCnt),     32'd0);

        // Sixteen steps wrap the counter.
        d0 = n_done;
        for (int i = 0; i < 16; i++) press(1'b0, 1'b1);
        repeat (6) tick();
        chk("wrap_pulses", 32'(n_done - d0), 32'd16);
        chk("wrap_cnt",    32'(stepCnt),     32'd0);

        // Random stimulus against the model.
        hr = 0;
        hs = 0;
        c0 = n_chk;
        for (int i = 0; i < 4000; i++) begin
            if (hr == 0) begin btnRun  = 1'($urandom_range(0, 1)); hr = $urandom_range(1, 10); end
            if (hs == 0) begin btnStep = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 10); end
            hr--;
            hs--;
            haltInstr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) div_en = ~div_en;
            if (!div_en && $urandom_range(0, 3) == 0) saidaClk = ~saidaClk;
            if ($urandom_range(0, 799) == 0) do_reset();
            else tick();
        end
        chk("random_ran", 32'(n_chk > c0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
